// File: rtl/freelist_if.sv
// Rename-side bundle between dispatch/retire (master) and the physical-register free list (slave).
interface freelist_if #(
    parameter int WAYS     = 3,
    parameter int PR_BITS  = 6,
    parameter int CNT_BITS = 6
);
    logic [WAYS-1:0]         new_pr_en;
    logic [WAYS-1:0]         retire_en;
    logic [WAYS*PR_BITS-1:0] retire_t_idx;
    logic [WAYS*PR_BITS-1:0] retire_told_idx;
    logic                    branch_flush_en;
    logic [WAYS*PR_BITS-1:0] t_idx;
    logic [WAYS-1:0]         t_valid;
    logic [CNT_BITS-1:0]     free_count;

    modport master (
        output new_pr_en, retire_en, retire_t_idx, retire_told_idx, branch_flush_en,
        input  t_idx, t_valid, free_count
    );

    modport slave (
        input  new_pr_en, retire_en, retire_t_idx, retire_told_idx, branch_flush_en,
        output t_idx, t_valid, free_count
    );
endinterface

// File: rtl/freelist.sv
// Physical-register free list: a ring of free tags with a speculative head, a retirement
// head used as the flush checkpoint, and a tail where retired Told tags are returned.
module freelist #(
    parameter int SUPERSCALAR_WAYS = 3,
    parameter int N_PHYS_REG       = 64,
    parameter int N_ARCH_REG       = 32,
    parameter int FL_DEPTH         = N_PHYS_REG - N_ARCH_REG
) (
    input logic       clock,
    input logic       reset,
    freelist_if.slave fl
);
    localparam int PR_BITS  = $clog2(N_PHYS_REG);
    localparam int IDX_BITS = $clog2(FL_DEPTH);
    localparam int PTR_BITS = IDX_BITS + 1;

    typedef logic [PTR_BITS-1:0] ptr_t;
    typedef logic [PR_BITS-1:0]  tag_t;

    tag_t ring_q [FL_DEPTH];
    tag_t ring_d [FL_DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t arch_head_q, arch_head_d;
    ptr_t count, n_pop, n_push;

    logic [SUPERSCALAR_WAYS*PR_BITS-1:0] t_idx_o;
    logic [SUPERSCALAR_WAYS-1:0]         t_valid_o;
    logic [SUPERSCALAR_WAYS-1:0]         pop_plus1;

    function automatic logic [IDX_BITS-1:0] ring_idx(input ptr_t p);
        return p[IDX_BITS-1:0];
    endfunction

    always_comb begin
        count     = tail_q - head_q;
        t_idx_o   = '0;
        t_valid_o = '0;
        for (int k = 0; k < SUPERSCALAR_WAYS; k++) begin
            t_idx_o[k*PR_BITS +: PR_BITS] = ring_q[ring_idx(head_q + ptr_t'(k))];
            t_valid_o[k]                  = (count > ptr_t'(k));
        end
    end

    assign fl.t_idx      = t_idx_o;
    assign fl.t_valid    = t_valid_o;
    assign fl.free_count = count;

    always_comb begin
        ring_d = ring_q;
        n_pop  = '0;
        n_push = '0;
        for (int w = 0; w < SUPERSCALAR_WAYS; w++) begin
            n_pop = n_pop + ptr_t'(fl.new_pr_en[w]);
        end
        // Retiring ways with a real destination append their Told in ascending way order.
        for (int w = 0; w < SUPERSCALAR_WAYS; w++) begin
            if (fl.retire_en[w] && (fl.retire_t_idx[w*PR_BITS +: PR_BITS] != '0)) begin
                ring_d[ring_idx(tail_q + n_push)] = fl.retire_told_idx[w*PR_BITS +: PR_BITS];
                n_push = n_push + ptr_t'(1);
            end
        end
        tail_d      = tail_q + n_push;
        arch_head_d = arch_head_q + n_push;
        // A flush rolls the speculative head back to the post-retirement checkpoint.
        head_d      = fl.branch_flush_en ? arch_head_d : head_q + n_pop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                ring_q[i] <= tag_t'(N_ARCH_REG + i);
            end
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= ptr_t'(FL_DEPTH);
        end else begin
            ring_q      <= ring_d;
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
        end
    end

    assign pop_plus1 = fl.new_pr_en + SUPERSCALAR_WAYS'(1);

    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        !fl.branch_flush_en |-> (n_pop <= count));
    a_packed_pop: assert property (@(posedge clock) disable iff (!reset)
        (fl.new_pr_en & pop_plus1) == '0);
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        ((count == ptr_t'(FL_DEPTH)) && !fl.branch_flush_en) |-> (n_push == '0));
endmodule

// File: tb/tb_freelist.sv
// Bench for the free list: directed scenarios with fixed expectations, then a randomized
// rename/retire/flush run checked against a queue-based model of free and in-flight tags.
module tb_freelist;
    localparam int WAYS = 3;
    localparam int PRB  = 6;
    localparam int CNTB = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;

    freelist_if #(.WAYS(WAYS), .PR_BITS(PRB), .CNT_BITS(CNTB)) fl ();

    freelist dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  fc;
        logic [2:0]  tv;
        logic [17:0] ti;
        logic [17:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   free_q[$];
    int   spec_q[$];
    int   arch_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        fl.new_pr_en       = '0;
        fl.retire_en       = '0;
        fl.retire_t_idx    = '0;
        fl.retire_told_idx = '0;
        fl.branch_flush_en = 1'b0;
    endtask

    // Apply one cycle of stimulus; returns 1 time unit after the capturing edge.
    task automatic drive(input logic [2:0] pop, input logic [2:0] ren, input logic [17:0] rt,
                         input logic [17:0] rto, input logic fls);
        fl.new_pr_en       = pop;
        fl.retire_en       = ren;
        fl.retire_t_idx    = rt;
        fl.retire_told_idx = rto;
        fl.branch_flush_en = fls;
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [17:0] tags3(input int a2, input int a1, input int a0);
        return {6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic check_outs(input string tag, input logic [17:0] ti, input logic [2:0] tv,
                              input logic [5:0] fc);
        check_eq({tag, "_t_idx"}, 32'(fl.t_idx), 32'(ti));
        check_eq({tag, "_t_valid"}, 32'(fl.t_valid), 32'(tv));
        check_eq({tag, "_free_count"}, 32'(fl.free_count), 32'(fc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();

        // 1: reset state holds while idle
        for (int c = 0; c < 5; c++) begin
            check_outs("reset_idle", tags3(34, 33, 32), 3'b111, 6'd32);
            drive(3'b000, 3'b000, '0, '0, 1'b0);
        end
        check_outs("reset_idle", tags3(34, 33, 32), 3'b111, 6'd32);

        // 2: pop two
        drive(3'b011, 3'b000, '0, '0, 1'b0);
        check_outs("pop2", tags3(36, 35, 34), 3'b111, 6'd30);

        // 3: drain completely, then one retire refills
        do_reset();
        for (int c = 0; c < 10; c++) drive(3'b111, 3'b000, '0, '0, 1'b0);
        drive(3'b011, 3'b000, '0, '0, 1'b0);
        check_eq("drain_free_count", 32'(fl.free_count), 32'd0);
        check_eq("drain_t_valid", 32'(fl.t_valid), 32'd0);
        drive(3'b000, 3'b001, 18'(32), 18'(5), 1'b0);
        check_eq("refill_t_idx0", 32'(fl.t_idx[5:0]), 32'd5);
        check_eq("refill_t_valid", 32'(fl.t_valid), 32'b001);
        check_eq("refill_free_count", 32'(fl.free_count), 32'd1);

        // 4: speculative pops rolled back by flush (pop request on flush cycle ignored)
        do_reset();
        drive(3'b111, 3'b000, '0, '0, 1'b0);
        drive(3'b111, 3'b000, '0, '0, 1'b0);
        check_outs("spec_pop6", tags3(40, 39, 38), 3'b111, 6'd26);
        drive(3'b001, 3'b000, '0, '0, 1'b1);
        check_outs("flush_restore", tags3(34, 33, 32), 3'b111, 6'd32);

        // 5: flush with same-cycle retire; the returned tag lands at ring[tail-1]
        drive(3'b000, 3'b001, 18'(32), 18'(7), 1'b1);
        check_outs("flush_retire", tags3(35, 34, 33), 3'b111, 6'd32);
        for (int c = 0; c < 10; c++) drive(3'b111, 3'b000, '0, '0, 1'b0);
        drive(3'b001, 3'b000, '0, '0, 1'b0);
        check_eq("wrap_told_t_idx0", 32'(fl.t_idx[5:0]), 32'd7);
        check_eq("wrap_told_t_valid", 32'(fl.t_valid), 32'b001);
        check_eq("wrap_told_free_count", 32'(fl.free_count), 32'd1);

        // 6: pop and push in one cycle; pushed tag not visible immediately
        do_reset();
        drive(3'b011, 3'b000, '0, '0, 1'b0);
        drive(3'b011, 3'b001, 18'(32), 18'(9), 1'b0);
        check_outs("pop_push", tags3(38, 37, 36), 3'b111, 6'd29);

        // Asynchronous reset in mid-cycle discards pending pops
        fl.new_pr_en = 3'b011;
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", tags3(34, 33, 32), 3'b111, 6'd32);
        @(posedge clock);
        #1;
        check_outs("reset_held", tags3(34, 33, 32), 3'b111, 6'd32);
        idle_inputs();
        reset = 1'b1;

        // Randomized run against the queue model
        do_reset();
        free_q.delete();
        spec_q.delete();
        arch_q.delete();
        for (int t = 32; t < 64; t++) free_q.push_back(t);
        for (int t = 1; t < 32; t++) arch_q.push_back(t);

        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [2:0]  pop, ren;
            logic [17:0] rt, rto;
            logic        fls, dup;
            int          used, np, maxp, idx;
            int          told_l[$];
            exp_t        e, got_e;

            fls  = ($urandom_range(0, 63) == 0);
            used = 0;
            ren  = '0;
            rt   = '0;
            rto  = '0;
            told_l.delete();
            for (int w = 0; w < WAYS; w++) begin
                int r;
                r = $urandom_range(0, 3);
                if (r < 2 && used < spec_q.size()) begin
                    ren[w]          = 1'b1;
                    rt[w*PRB +: PRB] = 6'(spec_q[used]);
                    idx              = $urandom_range(0, arch_q.size() - 1);
                    rto[w*PRB +: PRB] = 6'(arch_q[idx]);
                    told_l.push_back(arch_q[idx]);
                    arch_q.delete(idx);
                    used++;
                end else if (r == 2) begin
                    ren[w]            = 1'b1;
                    rto[w*PRB +: PRB] = 6'($urandom_range(0, 63));
                end else begin
                    rt[w*PRB +: PRB]  = 6'($urandom_range(1, 63));
                    rto[w*PRB +: PRB] = 6'($urandom_range(0, 63));
                end
            end

            maxp = (free_q.size() < 3) ? free_q.size() : 3;
            np   = fls ? $urandom_range(0, 3) : $urandom_range(0, maxp);
            pop  = 3'((1 << np) - 1);

            for (int i = 0; i < used; i++) begin
                arch_q.push_back(spec_q.pop_front());
                free_q.push_back(told_l[i]);
            end
            if (fls) begin
                free_q = {spec_q, free_q};
                spec_q.delete();
            end else begin
                for (int i = 0; i < np; i++) spec_q.push_back(free_q.pop_front());
            end

            e.fc   = 6'(free_q.size());
            e.tv   = '0;
            e.ti   = '0;
            e.mask = '0;
            for (int k = 0; k < WAYS; k++) begin
                if (k < free_q.size()) begin
                    e.tv[k]            = 1'b1;
                    e.ti[k*PRB +: PRB] = 6'(free_q[k]);
                    e.mask[k*PRB +: PRB] = '1;
                end
            end
            exp_q.push_back(e);

            drive(pop, ren, rt, rto, fls);

            got_e = exp_q.pop_front();
            check_eq("rnd_free_count", 32'(fl.free_count), 32'(got_e.fc));
            check_eq("rnd_t_valid", 32'(fl.t_valid), 32'(got_e.tv));
            check_eq("rnd_t_idx", 32'(fl.t_idx & got_e.mask), 32'(got_e.ti));
            dup = 1'b0;
            for (int a = 0; a < WAYS; a++)
                for (int b = a + 1; b < WAYS; b++)
                    if (fl.t_valid[a] && fl.t_valid[b] &&
                        fl.t_idx[a*PRB +: PRB] == fl.t_idx[b*PRB +: PRB]) dup = 1'b1;
            check_eq("rnd_no_dup", 32'(dup), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
